// File: rtl/stage_e_if.sv
// D/E-side operand and control bundle for the execute stage, plus its E/M-side results.
interface stage_e_if;
  logic        instr_valid_e;
  logic [31:0] forward_e1;
  logic [31:0] forward_e2;
  logic [31:0] imm32_e;
  logic [4:0]  shamt_e;
  logic        alu_src_e;
  logic [3:0]  alu_op_e;
  logic [2:0]  md_op_e;
  logic [1:0]  mf_sel_e;
  logic [31:0] alu_out_e;
  logic [31:0] wd_em;
  logic        start;
  logic        busy;

  modport master (
    output instr_valid_e, forward_e1, forward_e2, imm32_e, shamt_e,
           alu_src_e, alu_op_e, md_op_e, mf_sel_e,
    input  alu_out_e, wd_em, start, busy
  );

  modport slave (
    input  instr_valid_e, forward_e1, forward_e2, imm32_e, shamt_e,
           alu_src_e, alu_op_e, md_op_e, mf_sel_e,
    output alu_out_e, wd_em, start, busy
  );
endinterface

// File: rtl/stage_e.sv
// MIPS execute stage: combinational ALU / move-from mux and a fixed-latency
// multiply/divide unit that owns HI/LO.
module stage_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst,
  stage_e_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi, hi_n, lo, lo_n;
  logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_ok, pend_ok_n;

  logic [31:0] a, b, alu_res;

  assign a = bus.forward_e1;
  assign b = bus.alu_src_e ? bus.imm32_e : bus.forward_e2;

  always_comb begin
    alu_res = a;
    case (bus.alu_op_e)
      4'd0:  alu_res = a + b;
      4'd1:  alu_res = a - b;
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a ^ b;
      4'd5:  alu_res = ~(a | b);
      4'd6:  alu_res = {31'b0, $signed(a) < $signed(b)};
      4'd7:  alu_res = {31'b0, a < b};
      4'd8:  alu_res = b << bus.shamt_e;
      4'd9:  alu_res = b >> bus.shamt_e;
      4'd10: alu_res = $signed(b) >>> bus.shamt_e;
      4'd11: alu_res = b << a[4:0];
      4'd12: alu_res = b >> a[4:0];
      4'd13: alu_res = $signed(b) >>> a[4:0];
      4'd14: alu_res = {b[15:0], 16'h0000};
      default: alu_res = a;
    endcase
  end

  always_comb begin
    case (bus.mf_sel_e)
      2'd1:    bus.alu_out_e = hi;
      2'd2:    bus.alu_out_e = lo;
      default: bus.alu_out_e = alu_res;
    endcase
  end

  assign bus.wd_em = bus.forward_e2;
  assign bus.busy  = (state == BUSY);
  assign bus.start = bus.instr_valid_e && (bus.md_op_e >= 3'd1) && (bus.md_op_e <= 3'd4)
                     && (state == IDLE);

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead
  // of overflowing; a zero divisor is steered to 1 and its result never commits.
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs, a_mag, b_mag, uq, ur, q_s, r_s, q_u, r_u;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    dvs    = (b == '0) ? 32'd1 : b;
    a_mag  = a[31] ? -a : a;
    b_mag  = dvs[31] ? -dvs : dvs;
    uq     = a_mag / b_mag;
    ur     = a_mag % b_mag;
    q_s    = (a[31] ^ dvs[31]) ? -uq : uq;
    r_s    = a[31] ? -ur : ur;
    q_u    = a / dvs;
    r_u    = a % dvs;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_ok_n = pend_ok;
    case (state)
      IDLE: begin
        if (bus.instr_valid_e) begin
          case (bus.md_op_e)
            3'd1: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_ok_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = BUSY;
            end
            3'd2: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_ok_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = BUSY;
            end
            3'd3: begin
              pend_hi_n = r_s;
              pend_lo_n = q_s;
              pend_ok_n = (b != '0);
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = BUSY;
            end
            3'd4: begin
              pend_hi_n = r_u;
              pend_lo_n = q_u;
              pend_ok_n = (b != '0);
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = BUSY;
            end
            3'd5: hi_n = a;
            3'd6: lo_n = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          if (pend_ok) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_ok <= pend_ok_n;
    end
  end

endmodule

// File: doc/stage_e.md
Name: stage_e

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage.
- Consumes forwarded register operands, the extended immediate and decoded E-stage controls from the D/E pipeline register.
- Produces the ALU/move-from result and store data for the E/M register.
- Owns the multi-cycle multiply/divide unit (HI/LO). Exports Start/Busy so the hazard unit can stall MD-class instructions in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
InstrValidE  in  1  1 = E holds a real instruction; 0 = bubble
ForwardE1  in  32  forwarded rs operand (A)
ForwardE2  in  32  forwarded rt operand
Imm32E  in  32  extended immediate from D
ShamtE  in  5  instr[10:6]
ALUSrcE  in  1  0: B=ForwardE2, 1: B=Imm32E
ALUOpE  in  4  ALU operation code
MDOpE  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
MFSelE  in  2  0 ALU, 1 HI, 2 LO, 3 reserved (ALU)
ALUOutE  out  32  result to E/M register
WDEM  out  32  store data = ForwardE2
Start  out  1  combinational: MD op 1-4 issuing this cycle
Busy  out  1  registered: MDU computing

Behaviour:
- Reset (async, active-high): HI=0, LO=0, state IDLE, counter=0, Busy=0, pending results=0. Takes effect immediately, even mid-operation. An in-flight result is discarded.
- ALU (combinational, 32-bit wrap, no overflow trap). B per ALUSrcE. Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU.
  - 8 SLL B by ShamtE, 9 SRL, 10 SRA.
  - 11 SLLV B by A[4:0], 12 SRLV, 13 SRAV.
  - 14 LUI = {B[15:0],16'b0}, 15 PASS A.
- ALUOutE = HI when MFSelE=1, LO when MFSelE=2, else ALU result. ALUOutE is purely combinational, zero latency.
- MDU states: IDLE, BUSY.
- Start = InstrValidE & MDOpE in {1..4} & state==IDLE.
- On the edge with Start=1:
  - Capture the result from the current operands into pending HI/LO.
  - Load counter = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Go to BUSY.
- Busy = (state==BUSY). It is high for exactly N cycles after the issue cycle.
- In BUSY, the counter decrements each edge. On the edge where counter==1, commit pending to HI/LO and return to IDLE.
  - The first instruction able to read new HI/LO is in E the cycle after Busy falls.
- mult: {HI,LO} = signed 64-bit A*B. multu: unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (div/divu): still busy DIV_CYCLES. HI/LO are left unchanged at commit.
- mthi/mtlo (5/6): when InstrValidE and IDLE, HI (resp. LO) = A at the edge. No busy cycles.
- MD ops (1-6) arriving while BUSY are ignored (no state change). The hazard unit guarantees this never happens; the behaviour is defensive.
- A bubble (InstrValidE=0) never changes MDU state, regardless of MDOpE.
- Busy is unaffected by pipeline stall/flush. Only Reset aborts an operation.
- MFSelE≠0 while BUSY returns the old HI/LO; the hazard unit must stall.

Test Plan:
- ALU: A=0x7FFFFFFF, B=1, ADD -> 0x80000000. SLT A=0xFFFFFFFF, B=1 -> 1; SLTU -> 0. SRA B=0x80000000, shamt 4 -> 0xF8000000. LUI imm 0x1234 -> 0x12340000.
- mult: A=0xFFFFFFFE, B=3, valid for 1 cycle.
  - Start=1 that cycle, Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div: A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> Busy 10 cycles, HI/LO unchanged.
- mthi A=0xDEADBEEF then mflo/mfhi -> ALUOutE=0xDEADBEEF with MFSelE=1 on the next cycle. A bubble with MDOpE=5 leaves HI unchanged.
- Issue div, then at busy cycle 4 assert Reset -> Busy=0 immediately, HI=LO=0. After release, a mult completes normally with correct timing.
- While BUSY, present mult with InstrValidE=1 -> Start=0, counter and pending unchanged, original result committed on schedule.
